// File: rtl/zio_wrfifo.sv
// Z80 I/O write capture FIFO: filters port writes on the decoder strobe and queues {addr, data}
// for slower internal consumers, stalling the Z80 (or dropping and flagging) when full.
module zio_wrfifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3,
    parameter logic [15:0] PORT_MASK  = 16'h00FF,
    parameter logic [15:0] PORT_MATCH = 16'h00FE,
    parameter bit          USE_WAIT   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iowr_s_i,
    input  logic          iorq_i,
    input  logic [15:0]   a_i,
    input  logic [7:0]    d_i,
    output logic          wait_n_o,
    output logic          out_valid_o,
    output logic [15:0]   out_addr_o,
    output logic [7:0]    out_data_o,
    input  logic          out_ready_i,
    output logic [AW:0]   level_o,
    output logic          ovf_o,
    input  logic          ovf_clr_i
);

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   pend_addr_q, pend_addr_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          wait_n_q, wait_n_d;
    logic          ovf_q, ovf_d;

    logic [15:0]   addr_mem [DEPTH];
    logic [7:0]    data_mem [DEPTH];

    logic          hit, pop, full, push, ovf_set;
    logic [15:0]   push_addr;
    logic [7:0]    push_data;

    assign hit  = iowr_s_i && ((a_i & PORT_MASK) == PORT_MATCH);
    assign pop  = (level_q != '0) && out_ready_i;
    assign full = (level_q == (AW+1)'(DEPTH));

    always_comb begin
        state_d     = state_q;
        wait_n_d    = wait_n_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        push        = 1'b0;
        push_addr   = a_i;
        push_data   = d_i;
        ovf_set     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    if (!full || pop) begin
                        push = 1'b1;
                    end else if (USE_WAIT) begin
                        pend_addr_d = a_i;
                        pend_data_d = d_i;
                        wait_n_d    = 1'b0;
                        state_d     = StStall;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            StStall: begin
                push_addr = pend_addr_q;
                push_data = pend_data_q;
                // An iorq drop means the Z80 ended the cycle early; the entry may be lost.
                if (pop || !iorq_i) begin
                    push     = pop;
                    ovf_set  = !iorq_i;
                    wait_n_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    assign ovf_d = ovf_set ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            wait_n_q    <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            wait_n_q    <= wait_n_d;
            ovf_q       <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    assign wait_n_o    = wait_n_q;
    assign out_valid_o = (level_q != '0);
    assign out_addr_o  = addr_mem[rd_ptr_q];
    assign out_data_o  = data_mem[rd_ptr_q];
    assign level_o     = level_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_zio_wrfifo.sv
// Bench for zio_wrfifo: a stall-mode and a drop-mode instance share one stimulus stream.
module tb_zio_wrfifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iowr_s, iorq, out_ready, ovf_clr;
    logic [15:0] a;
    logic [7:0]  d;

    logic        w_wait_n, w_valid, w_ovf;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic [3:0]  w_level;

    logic        x_wait_n, x_valid, x_ovf;
    logic [15:0] x_addr;
    logic [7:0]  x_data;
    logic [3:0]  x_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    zio_wrfifo #(.USE_WAIT(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .iowr_s_i(iowr_s), .iorq_i(iorq), .a_i(a), .d_i(d),
        .wait_n_o(w_wait_n), .out_valid_o(w_valid), .out_addr_o(w_addr), .out_data_o(w_data),
        .out_ready_i(out_ready), .level_o(w_level), .ovf_o(w_ovf), .ovf_clr_i(ovf_clr)
    );

    zio_wrfifo #(.USE_WAIT(1'b0)) dut_d (
        .clk(clk), .rst_n(rst_n), .iowr_s_i(iowr_s), .iorq_i(iorq), .a_i(a), .d_i(d),
        .wait_n_o(x_wait_n), .out_valid_o(x_valid), .out_addr_o(x_addr), .out_data_o(x_data),
        .out_ready_i(out_ready), .level_o(x_level), .ovf_o(x_ovf), .ovf_clr_i(ovf_clr)
    );

    typedef struct {
        logic        iowr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rdy;
        logic        e_valid;
        logic        chk_head;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic [3:0]  e_level;
        logic        e_wait;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iowr_s    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        iorq  = 1'b1;
        a     = 16'h0000;
        d     = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            iowr_s = 1'b1;
            a      = 16'h00FE;
            d      = base + 8'(i);
            step();
        end
        iowr_s = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        iorq = 1'b1;
        a    = '0;
        d    = '0;

        // Single write, filter, push/pop, push+pop, mask boundary.
        vecs[0] = '{1'b1, 16'h12FE, 8'hA5, 1'b0, 1'b1, 1'b1, 16'h12FE, 8'hA5, 4'd1, 1'b1};
        vecs[1] = '{1'b1, 16'h00FD, 8'h33, 1'b0, 1'b1, 1'b1, 16'h12FE, 8'hA5, 4'd1, 1'b1};
        vecs[2] = '{1'b1, 16'h34FE, 8'h5A, 1'b0, 1'b1, 1'b1, 16'h12FE, 8'hA5, 4'd2, 1'b1};
        vecs[3] = '{1'b0, 16'h34FE, 8'h5A, 1'b1, 1'b1, 1'b1, 16'h34FE, 8'h5A, 4'd1, 1'b1};
        vecs[4] = '{1'b1, 16'h56FE, 8'hC3, 1'b1, 1'b1, 1'b1, 16'h56FE, 8'hC3, 4'd1, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 4'd0, 1'b1};
        vecs[6] = '{1'b1, 16'hABFE, 8'h11, 1'b0, 1'b1, 1'b1, 16'hABFE, 8'h11, 4'd1, 1'b1};
        vecs[7] = '{1'b1, 16'h00FF, 8'h22, 1'b0, 1'b1, 1'b1, 16'hABFE, 8'h11, 4'd1, 1'b1};

        do_reset();
        check("reset_valid", 32'(w_valid), 32'd0);
        check("reset_level", 32'(w_level), 32'd0);
        check("reset_wait", 32'(w_wait_n), 32'd1);
        check("reset_ovf", 32'(x_ovf), 32'd0);

        // Filter-only strobe from a clean FIFO.
        iowr_s = 1'b1; a = 16'h00FD; d = 8'h77;
        step();
        iowr_s = 1'b0;
        check("filter_level", 32'(w_level), 32'd0);
        check("filter_valid", 32'(w_valid), 32'd0);
        check("filter_wait", 32'(w_wait_n), 32'd1);

        for (int i = 0; i < 8; i++) begin
            iowr_s = vecs[i].iowr; a = vecs[i].a; d = vecs[i].d; out_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), 32'(w_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_level", i), 32'(w_level), 32'(vecs[i].e_level));
            check($sformatf("vec%0d_wait", i), 32'(w_wait_n), 32'(vecs[i].e_wait));
            if (vecs[i].chk_head) begin
                check($sformatf("vec%0d_addr", i), 32'(w_addr), 32'(vecs[i].e_addr));
                check($sformatf("vec%0d_data", i), 32'(w_data), 32'(vecs[i].e_data));
            end
        end
        idle_inputs();

        // Fill and stall, release by one pop, then drain in order 2..9.
        do_reset();
        fill(8'd1);
        check("fill_level", 32'(w_level), 32'd8);
        check("fill_wait", 32'(w_wait_n), 32'd1);
        iowr_s = 1'b1; a = 16'h00FE; d = 8'd9;
        step();
        iowr_s = 1'b0;
        check("stall_wait", 32'(w_wait_n), 32'd0);
        check("stall_level", 32'(w_level), 32'd8);
        step();
        check("stall_hold", 32'(w_wait_n), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_wait", 32'(w_wait_n), 32'd1);
        check("release_level", 32'(w_level), 32'd8);
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("drain_valid%0d", k), 32'(w_valid), 32'd1);
            check($sformatf("drain_data%0d", k), 32'(w_data), 32'(k));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(w_level), 32'd0);

        // Full FIFO with simultaneous pop: accepted without stalling.
        do_reset();
        fill(8'h10);
        iowr_s = 1'b1; a = 16'h00FE; d = 8'h20; out_ready = 1'b1;
        step();
        idle_inputs();
        check("fullpop_wait", 32'(w_wait_n), 32'd1);
        check("fullpop_level", 32'(w_level), 32'd8);
        check("fullpop_head", 32'(w_data), 32'h11);
        step();
        check("fullpop_wait2", 32'(w_wait_n), 32'd1);

        // Drop mode: overflow set, set beats clear, lone clear, dropped data not stored.
        do_reset();
        fill(8'd1);
        iowr_s = 1'b1; a = 16'h00FE; d = 8'h99;
        step();
        iowr_s = 1'b0;
        check("drop_ovf", 32'(x_ovf), 32'd1);
        check("drop_level", 32'(x_level), 32'd8);
        check("drop_wait", 32'(x_wait_n), 32'd1);
        iowr_s = 1'b1; d = 8'h9A; ovf_clr = 1'b1;
        step();
        iowr_s = 1'b0;
        check("drop_setwins", 32'(x_ovf), 32'd1);
        step();
        ovf_clr = 1'b0;
        check("drop_clr", 32'(x_ovf), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drop_order%0d", k), 32'(x_data), 32'(k));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("drop_empty", 32'(x_valid), 32'd0);

        // iorq drop while stalled: pending discarded, ovf set, wait released.
        do_reset();
        fill(8'd1);
        iowr_s = 1'b1; a = 16'h00FE; d = 8'd9;
        step();
        iowr_s = 1'b0;
        check("abort_stall", 32'(w_wait_n), 32'd0);
        iorq = 1'b0;
        step();
        iorq = 1'b1;
        check("abort_wait", 32'(w_wait_n), 32'd1);
        check("abort_ovf", 32'(w_ovf), 32'd1);
        check("abort_level", 32'(w_level), 32'd8);
        check("abort_head", 32'(w_data), 32'd1);

        // Asynchronous reset mid-stall, observed between clock edges.
        do_reset();
        fill(8'd1);
        iowr_s = 1'b1; a = 16'h00FE; d = 8'd9;
        step();
        iowr_s = 1'b0;
        check("areset_pre", 32'(w_wait_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("areset_wait", 32'(w_wait_n), 32'd1);
        check("areset_valid", 32'(w_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("areset_level", 32'(w_level), 32'd0);
        check("areset_wait2", 32'(w_wait_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zio_wrfifo.md
Name: zio_wrfifo

Overview:
- Downstream consumer of the Z80 signal decoder's one-clock `iowr_s` strobe.
- Captures filtered Z80 I/O port writes (port address and data) into a small FIFO.
- Hands them to slower internal engines (sound, DMA set-up, config registers) over a valid/ready interface.
- When the FIFO is full, the write is held off by pulling Z80 WAIT low, or it is dropped and flagged, depending on `USE_WAIT`.

Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of 2, minimum 2.
- `AW`, default 3: log2(`DEPTH`), the pointer width.
- `PORT_MASK`, default 16'h00FF: address bits compared for port match.
- `PORT_MATCH`, default 16'h00FE: required value of (a & `PORT_MASK`).
- `USE_WAIT`, default 1: 1 = stall the Z80 on full; 0 = drop the write and set `ovf`.

Ports:
- `clk`  in  1  FPGA system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `iowr_s`  in  1  one-clock strobe, start of a Z80 I/O write cycle.
- `iorq`  in  1  level, I/O request active (M1-masked).
- `a`  in  16  Z80 address bus.
- `d`  in  8  Z80 data bus.
- `wait_n`  out  1  Z80 WAIT, active low.
- `out_valid`  out  1  FIFO head valid.
- `out_addr`  out  16  head port address.
- `out_data`  out  8  head data.
- `out_ready`  in  1  consumer accepts the head.
- `level`  out  AW+1  entry count, 0..`DEPTH`.
- `ovf`  out  1  sticky dropped-write flag.
- `ovf_clr`  in  1  clears `ovf`.

Behaviour:
- Reset, asynchronous on `rst_n` low:
  - pointers = 0, `level` = 0, `out_valid` = 0
  - `wait_n` = 1 immediately, not clock-gated
  - `ovf` = 0, FSM = IDLE
  - `out_addr`/`out_data` are don't-care while `out_valid` = 0
- Match: hit = `iowr_s` && ((a & `PORT_MASK`) == `PORT_MATCH`). Non-hit strobes are ignored entirely.
- Pop: pop = `out_valid` && `out_ready`. The read pointer advances on that edge.
- FIFO data path:
  - Show-ahead: `out_addr`/`out_data` present the entry at the read pointer.
  - `out_valid` = (`level` != 0).
  - Pointers wrap modulo `DEPTH`.
  - `level` is +1 on push only, -1 on pop only, unchanged on push+pop.
- Push latency: a hit captured at clock edge N sets `out_valid` = 1 after edge N (visible in cycle N+1).
- FSM states: IDLE, STALL.
- IDLE:
  - hit && (`level` < `DEPTH` || pop): push {a,d} this edge and stay in IDLE. A push into a full FIFO is allowed when pop is in the same cycle.
  - hit && full && !pop, with `USE_WAIT` = 1: latch {a,d} into a pending register, go to STALL, `wait_n` <= 0.
  - hit && full && !pop, with `USE_WAIT` = 0: discard, `ovf` <= 1, stay in IDLE.
- STALL:
  - `wait_n` = 0.
  - On pop: push the pending entry on the same edge (net `level` unchanged), `wait_n` <= 1, go to IDLE.
  - If `iorq` drops while in STALL (abnormal cycle end): push anyway if pop, else discard pending; set `ovf` = 1; go to IDLE, `wait_n` = 1.
- `ovf`:
  - Set wins over `ovf_clr` in the same cycle.
  - Otherwise `ovf_clr` clears it on the next edge.
- `wait_n` is registered and glitch-free. It goes low one clock after the stalling strobe, which is still within Z80 T2 at `zpos` rate.
- Entries leave the FIFO in strict order of acceptance.
- Reset mid-STALL: the pending entry is lost, `wait_n` = 1, the FIFO is emptied.

Test Plan:
- Single write: `a` = 16'h12FE, `d` = 8'hA5, one `iowr_s`, `out_ready` = 0 -> next cycle `out_valid` = 1, `out_addr` = 16'h12FE, `out_data` = 8'hA5, `level` = 1.
- Filter: `iowr_s` with `a` = 16'h00FD -> `level` stays 0, `out_valid` stays 0, `wait_n` stays 1.
- Fill and stall (`USE_WAIT` = 1): 8 hits with `d` = 1..8, then a 9th with `d` = 9, `out_ready` = 0 -> `level` = 8, `wait_n` = 0 from the next cycle. Pulse `out_ready` for 1 cycle -> pops `d` = 1, `level` stays 8, `wait_n` = 1 next cycle. Drain order = 2..9.
- Full+pop same cycle: FIFO full, hit with `out_ready` = 1 -> no stall, `wait_n` stays 1, `level` stays 8.
- Drop mode (`USE_WAIT` = 0): full FIFO, hit -> `ovf` = 1, `level` = 8, data not stored. `ovf_clr` pulse concurrent with another dropped hit -> `ovf` stays 1. A later lone `ovf_clr` -> 0.
- Async reset in STALL: drive `rst_n` = 0 between clock edges -> `wait_n` = 1 and `out_valid` = 0 without a clock edge. After release, `level` = 0.
